sdram_arbiter: RTL and testbench

- Shares the single sdram controller port (req/ack/valid, 23-bit word address, 32-bit data) among NREQ requesters in the clk_draw domain, e.g. sprite/tile fetch, host writes and line-buffer fill.
- Selects one pending requester, registers its command and holds ram_req until ram_ack.
- Tags each accepted read in an in-order tag FIFO so that ram_valid/ram_q can be routed back to the requester that issued the read.

---
 rtl/sdram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NREQ requesters, with an in-order read tag FIFO.
// Define SDRAM_ARB_PRIO0_EN to give requester 0 fixed top priority over the round-robin group.
module sdram_arbiter #(
  parameter int NREQ     = 4,
  parameter int TAGDEPTH = 4,
  parameter int AW       = 23,
  parameter int DW       = 32
) (
  input  logic               clk_draw,
  input  logic               rst_draw,
  input  logic [NREQ-1:0]    m_req,
  input  logic [NREQ-1:0]    m_we,
  input  logic [NREQ*AW-1:0] m_addr,
  input  logic [NREQ*DW-1:0] m_data,
  output logic [NREQ-1:0]    m_ack,
  output logic [NREQ-1:0]    m_valid,
  output logic [DW-1:0]      m_q,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic               ram_we,
  output logic               ram_req,
  input  logic               ram_ack,
  input  logic               ram_valid,
  input  logic [DW-1:0]      ram_q,
  output logic               busy,
  output logic               err_underflow
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TAGDEPTH);
  localparam logic [TW:0]   FULL_CNT = (TW+1)'(TAGDEPTH);
  localparam logic [GW-1:0] LAST_IDX = GW'(NREQ-1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t        state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] sel_idx;
  logic          sel_found;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] search;
  logic [GW-1:0] tags [TAGDEPTH];
  logic [TW-1:0] wr_ptr;
  logic [TW-1:0] rd_ptr;
  logic [TW:0]   count;
  logic          push;
  logic          pop;

  // Reads stall while every tag slot is in use; writes never need a tag.
  assign eligible = m_req & (m_we | {NREQ{count != FULL_CNT}});

`ifdef SDRAM_ARB_PRIO0_EN
  assign search = {eligible[NREQ-1:1], 1'b0};
`else
  assign search = eligible;
`endif

  always_comb begin
    int            idx;
    logic [GW-1:0] idx_v;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NREQ;
      idx_v = idx[GW-1:0];
      if (!sel_found && search[idx_v]) begin
        sel_found = 1'b1;
        sel_idx   = idx_v;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    if (eligible[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  assign push  = (state == ISSUE) && ram_ack && !ram_we;
  assign pop   = ram_valid && (count != '0);
  assign m_q   = ram_q;
  assign busy  = (state == ISSUE) || (count != '0);

  always_comb begin
    m_ack   = '0;
    m_valid = '0;
    if ((state == ISSUE) && ram_ack)
      m_ack[grant] = 1'b1;
    if (pop)
      m_valid[tags[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= LAST_IDX;
      ram_req  <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant    <= sel_idx;
            ram_addr <= m_addr[sel_idx*AW +: AW];
            ram_data <= m_data[sel_idx*DW +: DW];
            ram_we   <= m_we[sel_idx];
            ram_req  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            state   <= IDLE;
`ifdef SDRAM_ARB_PRIO0_EN
            if (grant != '0)
              rr_ptr <= grant;
`else
            rr_ptr <= grant;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_draw) begin
    if (push)
      tags[wr_ptr] <= grant;
  end

  // Push and pop in the same cycle leave the count unchanged, even when full.
  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (ram_valid && (count == '0))
        err_underflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sdram_arbiter;
  localparam int NREQ = 4;
  localparam int TAGDEPTH = 4;
  localparam int AW = 23;
  localparam int DW = 32;

  logic               clk_draw = 1'b0;
  logic               rst_draw;
  logic [NREQ-1:0]    m_req;
  logic [NREQ-1:0]    m_we;
  logic [NREQ*AW-1:0] m_addr;
  logic [NREQ*DW-1:0] m_data;
  logic [NREQ-1:0]    m_ack;
  logic [NREQ-1:0]    m_valid;
  logic [DW-1:0]      m_q;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_data;
  logic               ram_we;
  logic               ram_req;
  logic               ram_ack;
  logic               ram_valid;
  logic [DW-1:0]      ram_q;
  logic               busy;
  logic               err_underflow;

  sdram_arbiter #(.NREQ(NREQ), .TAGDEPTH(TAGDEPTH), .AW(AW), .DW(DW)) dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .m_ack(m_ack), .m_valid(m_valid), .m_q(m_q),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_req(ram_req),
    .ram_ack(ram_ack), .ram_valid(ram_valid), .ram_q(ram_q),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk_draw = ~clk_draw;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding command, a queue of read owners, a round-robin pointer.
  bit          mdl_busy;
  int          mdl_grant;
  bit          mdl_we;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_data;
  int          mdl_rr;
  int          tagq[$];
  bit          mdl_err;
  int          busy_age;
  int          cur_delay;

  bit rand_req, rand_ack, auto_ret, drop_on_ack;
  int ack_delay;

  int          ack_log[$];
  int          vld_idx[$];
  logic [DW-1:0] vld_q[$];

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[i] = 1'b1;
    m_we[i]  = we;
    m_addr[i*AW +: AW] = a;
    m_data[i*DW +: DW] = d;
  endtask

  function automatic int pick();
    bit e[NREQ];
    int j;
    for (int i = 0; i < NREQ; i++)
      e[i] = m_req[i] && (m_we[i] || tagq.size() < TAGDEPTH);
`ifdef SDRAM_ARB_PRIO0_EN
    if (e[0]) return 0;
    e[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      j = (mdl_rr + k) % NREQ;
      if (e[j]) return j;
    end
    return -1;
  endfunction

  function automatic int ack_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  task automatic step_cycle();
    logic [NREQ-1:0] exp_ack;
    logic [NREQ-1:0] exp_valid;
    int g;
    #1;
    exp_ack = '0;
    if (mdl_busy && ram_ack) exp_ack[mdl_grant] = 1'b1;
    exp_valid = '0;
    if (ram_valid && tagq.size() > 0) exp_valid[tagq[0]] = 1'b1;
    if (!rst_draw) begin
      check_output("ram_req", ram_req, mdl_busy);
      if (mdl_busy) begin
        check_output("ram_addr", ram_addr, mdl_addr);
        check_output("ram_we", ram_we, mdl_we);
        check_output("ram_data", ram_data, mdl_data);
      end
      check_output("m_ack", m_ack, exp_ack);
      check_output("m_valid", m_valid, exp_valid);
      if (exp_valid != '0) check_output("m_q", m_q, ram_q);
      check_output("busy", busy, mdl_busy || tagq.size() != 0);
      check_output("err_underflow", err_underflow, mdl_err);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (m_ack[i]) ack_log.push_back(i);
      if (m_valid[i]) begin
        vld_idx.push_back(i);
        vld_q.push_back(m_q);
      end
    end
    if (rst_draw) begin
      mdl_busy = 0; mdl_rr = NREQ - 1; tagq.delete(); mdl_err = 0;
      mdl_addr = '0; mdl_data = '0; mdl_we = 0; busy_age = 0;
    end else begin
      g = mdl_busy ? -1 : pick();
      if (ram_valid) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else mdl_err = 1;
      end
      if (mdl_busy) begin
        if (ram_ack) begin
          if (!mdl_we) tagq.push_back(mdl_grant);
`ifdef SDRAM_ARB_PRIO0_EN
          if (mdl_grant != 0) mdl_rr = mdl_grant;
`else
          mdl_rr = mdl_grant;
`endif
          mdl_busy = 0;
        end else begin
          busy_age++;
        end
      end else if (g >= 0) begin
        mdl_busy  = 1;
        mdl_grant = g;
        mdl_we    = m_we[g];
        mdl_addr  = m_addr[g*AW +: AW];
        mdl_data  = m_data[g*DW +: DW];
        busy_age  = 0;
        cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
      end
    end
    @(posedge clk_draw);
    @(negedge clk_draw);
    ram_ack = mdl_busy && (busy_age >= cur_delay);
    if (auto_ret) begin
      ram_valid = (tagq.size() > 0) && ($urandom_range(0, 2) == 0);
      ram_q     = $urandom;
    end else begin
      ram_valid = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ack[i]) begin
        if (rand_req && $urandom_range(0, 1) == 1)
          apply_stimulus(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        else if (rand_req || drop_on_ack)
          m_req[i] = 1'b0;
      end else if (rand_req && !m_req[i] && $urandom_range(0, 3) == 0) begin
        apply_stimulus(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      end
    end
  endtask

  task automatic do_reset();
    rand_req = 0; rand_ack = 0; auto_ret = 0; drop_on_ack = 1; ack_delay = 0;
    m_req = '0; m_we = '0; ram_valid = 0;
    rst_draw = 1'b1;
    step_cycle();
    step_cycle();
    rst_draw = 1'b0;
    ack_log.delete(); vld_idx.delete(); vld_q.delete();
  endtask

  task automatic run_until_acks(input int n, input int limit);
    int c = 0;
    while (ack_log.size() < n && c < limit) begin
      step_cycle();
      c++;
    end
    check_output("ack_count", ack_log.size(), n);
  endtask

  initial begin
    int steps;
    m_addr = '0; m_data = '0; ram_ack = 0; ram_q = '0; cur_delay = 0;
    do_reset();
    check_output("rst_ram_req", ram_req, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_err", err_underflow, 0);
    check_output("rst_ram_addr", ram_addr, 0);

    // Single read from requester 2, controller acks two cycles after ram_req.
    ack_delay = 2;
    apply_stimulus(2, 1'b0, 23'h000123, 32'h0);
    steps = 0;
    while (ack_log.size() < 1 && steps < 20) begin step_cycle(); steps++; end
    check_output("single_ack_idx", ack_at(0), 2);
    check_output("single_latency", steps, 4);
    ram_valid = 1'b1; ram_q = 32'hDEADBEEF;
    step_cycle();
    check_output("single_vld_cnt", vld_idx.size(), 1);
    if (vld_idx.size() == 1) begin
      check_output("single_vld_idx", vld_idx[0], 2);
      check_output("single_vld_q", vld_q[0], 32'hDEADBEEF);
    end

    // Round robin with all four requesters reading continuously.
    do_reset();
    drop_on_ack = 0; auto_ret = 1;
    for (int i = 0; i < NREQ; i++) apply_stimulus(i, 1'b0, AW'(i * 16), 32'h0);
    run_until_acks(8, 200);
    for (int i = 0; i < 8; i++) check_output("rr_order", ack_at(i), i % NREQ);

    // Tag FIFO full: reads stall, writes still go through.
    do_reset();
    for (int i = 0; i < NREQ; i++) apply_stimulus(i, 1'b0, AW'(i + 1), 32'h0);
    run_until_acks(4, 40);
    ack_log.delete();
    apply_stimulus(1, 1'b0, 23'h000011, 32'h0);
    apply_stimulus(3, 1'b1, 23'h000033, 32'hCAFE0003);
    for (int i = 0; i < 6; i++) step_cycle();
    check_output("full_ack_cnt", ack_log.size(), 1);
    check_output("full_write_first", ack_at(0), 3);
    ram_valid = 1'b1; ram_q = 32'h5;
    step_cycle();
    run_until_acks(2, 20);
    check_output("full_read_after", ack_at(1), 1);

    // In-order return from requesters 3, 0, 2.
    do_reset();
    apply_stimulus(3, 1'b0, 23'h300, 32'h0);
    run_until_acks(1, 20);
    apply_stimulus(0, 1'b0, 23'h000, 32'h0);
    run_until_acks(2, 20);
    apply_stimulus(2, 1'b0, 23'h200, 32'h0);
    run_until_acks(3, 20);
    for (int i = 1; i <= 3; i++) begin
      ram_valid = 1'b1; ram_q = DW'(i);
      step_cycle();
    end
    check_output("order_vld_cnt", vld_idx.size(), 3);
    if (vld_idx.size() == 3) begin
      check_output("order_idx0", vld_idx[0], 3);
      check_output("order_idx1", vld_idx[1], 0);
      check_output("order_idx2", vld_idx[2], 2);
      check_output("order_q0", vld_q[0], 1);
      check_output("order_q1", vld_q[1], 2);
      check_output("order_q2", vld_q[2], 3);
    end

    // Underflow, then reset while a command is in ISSUE.
    do_reset();
    ram_valid = 1'b1; ram_q = 32'h77;
    step_cycle();
    check_output("uflow_flag", err_underflow, 1);
    check_output("uflow_no_valid", vld_idx.size(), 0);
    ack_delay = 5;
    apply_stimulus(0, 1'b0, 23'h0ABC, 32'h0);
    step_cycle();
    step_cycle();
    check_output("issue_req", ram_req, 1);
    rst_draw = 1'b1;
    step_cycle();
    rst_draw = 1'b0;
    m_req = '0;
    check_output("rst_mid_req", ram_req, 0);
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_err", err_underflow, 0);

    // Requesters 0 and 1 both requesting continuously.
    do_reset();
    drop_on_ack = 0; auto_ret = 1;
    apply_stimulus(0, 1'b0, 23'h10, 32'h0);
    apply_stimulus(1, 1'b0, 23'h20, 32'h0);
    run_until_acks(6, 200);
    for (int i = 0; i < 6; i++) begin
`ifdef SDRAM_ARB_PRIO0_EN
      check_output("prio_order", ack_at(i), 0);
`else
      check_output("pair_order", ack_at(i), i % 2);
`endif
    end

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    rand_req = 1; rand_ack = 1; auto_ret = 1;
    for (int i = 0; i < 3000; i++) step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
